bpi_cmd_sequencer: RTL and testbench



---
 rtl/bpi_seq_pkg.sv | 81 ++++++++
 rtl/bpi_step.sv | 72 +++++++
 rtl/bpi_cmd_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_bpi_cmd_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bpi_seq_pkg.sv
// Shared definitions for the BPI command sequencer: request codes, P30 flash
// opcodes, bus-step encodings, FSM states and status-register bit positions.
package bpi_seq_pkg;

    localparam logic [2:0] CMD_READ       = 3'd0;
    localparam logic [2:0] CMD_PROGRAM    = 3'd1;
    localparam logic [2:0] CMD_ERASE      = 3'd2;
    localparam logic [2:0] CMD_UNLOCK     = 3'd3;
    localparam logic [2:0] CMD_LOCK       = 3'd4;
    localparam logic [2:0] CMD_RD_STATUS  = 3'd5;
    localparam logic [2:0] CMD_CLR_STATUS = 3'd6;
    localparam logic [2:0] CMD_ILLEGAL    = 3'd7;

    localparam logic [15:0] FL_READ_ARRAY   = 16'h00FF;
    localparam logic [15:0] FL_PROGRAM      = 16'h0040;
    localparam logic [15:0] FL_ERASE        = 16'h0020;
    localparam logic [15:0] FL_CONFIRM      = 16'h00D0;
    localparam logic [15:0] FL_LOCK_SETUP   = 16'h0060;
    localparam logic [15:0] FL_LOCK_SET     = 16'h0001;
    localparam logic [15:0] FL_READ_STATUS  = 16'h0070;
    localparam logic [15:0] FL_CLEAR_STATUS = 16'h0050;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_RSVD  = 2'd3
    } bus_op_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DECODE,
        ST_STEP_ISSUE,
        ST_STEP_WAIT,
        ST_POLL_CMD,
        ST_POLL_READ,
        ST_POLL_CHK,
        ST_CLR_STAT,
        ST_FIN,
        ST_DONE
    } seq_state_t;

    localparam int SR_READY  = 7;
    localparam int SR_ERR_HI = 5;
    localparam int SR_ERR_LO = 1;

    typedef struct packed {
        bus_op_t     op;
        logic [15:0] data;
    } step_cmd_t;

    // Opening (idx 0) and second (idx 1) bus step of each request before any polling.
    function automatic step_cmd_t seq_step(input logic [2:0] code, input logic idx,
                                           input logic [15:0] wdata);
        seq_step = '{op: OP_WRITE, data: FL_READ_ARRAY};
        if (!idx) begin
            case (code)
                CMD_PROGRAM:            seq_step.data = FL_PROGRAM;
                CMD_ERASE:              seq_step.data = FL_ERASE;
                CMD_UNLOCK, CMD_LOCK:   seq_step.data = FL_LOCK_SETUP;
                CMD_RD_STATUS:          seq_step.data = FL_READ_STATUS;
                CMD_CLR_STATUS:         seq_step.data = FL_CLEAR_STATUS;
                default:                seq_step.data = FL_READ_ARRAY;
            endcase
        end else begin
            case (code)
                CMD_READ, CMD_RD_STATUS: seq_step = '{op: OP_READ, data: 16'h0000};
                CMD_PROGRAM:             seq_step.data = wdata;
                CMD_ERASE, CMD_UNLOCK:   seq_step.data = FL_CONFIRM;
                CMD_LOCK:                seq_step.data = FL_LOCK_SET;
                default:                 seq_step.data = FL_READ_ARRAY;
            endcase
        end
    endfunction

    function automatic logic needs_poll(input logic [2:0] code);
        return (code == CMD_PROGRAM) || (code == CMD_ERASE) ||
               (code == CMD_UNLOCK)  || (code == CMD_LOCK);
    endfunction

endpackage

// File: rtl/bpi_step.sv
// Single BPI bus step: latches the step, pulses EXECUTE once, holds the bus
// fields and reports completion (guarded BUSY low for writes, LOAD_DATA for reads).
module bpi_step
    import bpi_seq_pkg::*;
#(
    parameter int GUARD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_go,
    input  bus_op_t     step_op,
    input  logic [22:0] step_addr,
    input  logic [15:0] step_data,
    input  logic        busy,
    input  logic        load_data,
    input  logic [15:0] data_in,
    output bus_op_t     op,
    output logic [22:0] addr,
    output logic [15:0] cmd_data,
    output logic        execute,
    output logic        step_done,
    output logic [15:0] step_rdata
);

    localparam logic [7:0] GUARD_CNT = 8'(GUARD);

    logic        active;
    logic [7:0]  guard_cnt;
    logic [15:0] rdata_q;
    logic        write_done;
    logic        read_done;

    // guard_cnt is 0 in the EXECUTE cycle and saturates at GUARD, so BUSY is
    // ignored until the flash interface has had time to raise it.
    assign write_done = active && (op == OP_WRITE) && (guard_cnt >= GUARD_CNT) && !busy;
    assign read_done  = active && (op == OP_READ) && !execute && load_data;
    assign step_done  = write_done || read_done;
    assign step_rdata = read_done ? data_in : rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= 1'b0;
            execute   <= 1'b0;
            op        <= OP_NOP;
            addr      <= '0;
            cmd_data  <= '0;
            guard_cnt <= '0;
            rdata_q   <= '0;
        end else begin
            execute <= 1'b0;
            if (!active) begin
                if (step_go) begin
                    active    <= 1'b1;
                    execute   <= 1'b1;
                    op        <= step_op;
                    addr      <= step_addr;
                    cmd_data  <= step_data;
                    guard_cnt <= '0;
                end
            end else if (step_done) begin
                active <= 1'b0;
                op     <= OP_NOP;
                if (op == OP_READ) begin
                    rdata_q <= data_in;
                end
            end else if (guard_cnt < GUARD_CNT) begin
                guard_cnt <= guard_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/bpi_cmd_sequencer.sv
// Command-level P30 flash controller: expands one user request into bus steps
// for bpi_interface, polls the status register and restores read-array mode.
module bpi_cmd_sequencer
    import bpi_seq_pkg::*;
#(
    parameter int POLL_MAX = 65535,
    parameter int GUARD    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_REQ,
    input  logic [2:0]  CMD_CODE,
    input  logic [22:0] USR_ADDR,
    input  logic [15:0] USR_WDATA,
    output logic        SEQ_BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        TMO,
    output logic [15:0] RDATA,
    output logic [7:0]  STATUS,
    output logic [22:0] ADDR,
    output logic [15:0] CMD_DATA_OUT,
    output logic [1:0]  OP,
    output logic        EXECUTE,
    input  logic        BUSY,
    input  logic        LOAD_DATA,
    input  logic [15:0] DATA_IN
);

    localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

    seq_state_t  state, state_next;
    logic [2:0]  code_q;
    logic [22:0] addr_q;
    logic [15:0] wdata_q;
    logic        step_idx;
    logic        issued;
    logic [15:0] poll_cnt;
    logic        err_q, tmo_q;
    logic [15:0] rdata_q;
    logic [7:0]  status_q;

    logic        step_go;
    step_cmd_t   step_cmd;
    logic        step_done;
    logic [15:0] step_rdata;
    bus_op_t     bus_op;
    logic        last_idx;
    logic        read_result;

    assign last_idx    = (code_q != CMD_CLR_STATUS);
    assign read_result = step_idx && ((code_q == CMD_READ) || (code_q == CMD_RD_STATUS));

    bpi_step #(.GUARD(GUARD)) u_step (
        .clk        (CLK),
        .rst        (RST),
        .step_go    (step_go),
        .step_op    (step_cmd.op),
        .step_addr  (addr_q),
        .step_data  (step_cmd.data),
        .busy       (BUSY),
        .load_data  (LOAD_DATA),
        .data_in    (DATA_IN),
        .op         (bus_op),
        .addr       (ADDR),
        .cmd_data   (CMD_DATA_OUT),
        .execute    (EXECUTE),
        .step_done  (step_done),
        .step_rdata (step_rdata)
    );

    assign OP       = bus_op;
    assign SEQ_BUSY = (state != ST_IDLE);
    assign DONE     = (state == ST_DONE);
    assign ERR      = err_q;
    assign TMO      = tmo_q;
    assign RDATA    = rdata_q;
    assign STATUS   = status_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Poll/clear/fin states issue their single step on entry, then wait on step_done.
    always_comb begin
        state_next = state;
        step_go    = 1'b0;
        step_cmd   = '{op: OP_NOP, data: 16'h0000};
        unique case (state)
            ST_IDLE:       if (CMD_REQ) state_next = ST_DECODE;
            ST_DECODE:     state_next = (code_q == CMD_ILLEGAL) ? ST_DONE : ST_STEP_ISSUE;
            ST_STEP_ISSUE: begin
                step_cmd   = seq_step(code_q, step_idx, wdata_q);
                step_go    = 1'b1;
                state_next = ST_STEP_WAIT;
            end
            ST_STEP_WAIT: begin
                if (step_done) begin
                    if (step_idx != last_idx) state_next = ST_STEP_ISSUE;
                    else if (needs_poll(code_q)) state_next = ST_POLL_CMD;
                    else state_next = ST_DONE;
                end
            end
            ST_POLL_CMD: begin
                step_cmd = '{op: OP_WRITE, data: FL_READ_STATUS};
                step_go  = !issued;
                if (issued && step_done) state_next = ST_POLL_READ;
            end
            ST_POLL_READ: begin
                step_cmd = '{op: OP_READ, data: 16'h0000};
                step_go  = !issued;
                if (issued && step_done) state_next = ST_POLL_CHK;
            end
            ST_POLL_CHK: begin
                if (status_q[SR_READY]) begin
                    state_next = (|status_q[SR_ERR_HI:SR_ERR_LO]) ? ST_CLR_STAT : ST_FIN;
                end else if (poll_cnt >= POLL_LIMIT) begin
                    state_next = ST_FIN;
                end else begin
                    state_next = ST_POLL_READ;
                end
            end
            ST_CLR_STAT: begin
                step_cmd = '{op: OP_WRITE, data: FL_CLEAR_STATUS};
                step_go  = !issued;
                if (issued && step_done) state_next = ST_FIN;
            end
            ST_FIN: begin
                step_cmd = '{op: OP_WRITE, data: FL_READ_ARRAY};
                step_go  = !issued;
                if (issued && step_done) state_next = ST_DONE;
            end
            ST_DONE:       state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            code_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            step_idx <= 1'b0;
            issued   <= 1'b0;
            poll_cnt <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            rdata_q  <= '0;
            status_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (CMD_REQ) begin
                        code_q   <= CMD_CODE;
                        addr_q   <= USR_ADDR;
                        wdata_q  <= USR_WDATA;
                        err_q    <= 1'b0;
                        tmo_q    <= 1'b0;
                        step_idx <= 1'b0;
                        issued   <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    if (code_q == CMD_ILLEGAL) err_q <= 1'b1;
                end
                ST_STEP_WAIT: begin
                    if (step_done) begin
                        step_idx <= ~step_idx;
                        if (read_result) begin
                            rdata_q <= step_rdata;
                            if (code_q == CMD_RD_STATUS) status_q <= step_rdata[7:0];
                        end
                    end
                end
                ST_POLL_CMD, ST_POLL_READ, ST_CLR_STAT, ST_FIN: begin
                    if (!issued) begin
                        issued <= 1'b1;
                    end else if (step_done) begin
                        issued <= 1'b0;
                        if (state == ST_POLL_CMD) poll_cnt <= '0;
                        if (state == ST_POLL_READ) begin
                            status_q <= step_rdata[7:0];
                            poll_cnt <= poll_cnt + 16'd1;
                        end
                    end
                end
                ST_POLL_CHK: begin
                    if (status_q[SR_READY]) begin
                        if (|status_q[SR_ERR_HI:SR_ERR_LO]) err_q <= 1'b1;
                    end else if (poll_cnt >= POLL_LIMIT) begin
                        tmo_q <= 1'b1;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bpi_cmd_sequencer.sv
// Directed bench for bpi_cmd_sequencer with a behavioural bpi_interface model
// that logs every EXECUTE and answers reads from a response queue.
module tb_bpi_cmd_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CMD_REQ;
    logic [2:0]  CMD_CODE;
    logic [22:0] USR_ADDR;
    logic [15:0] USR_WDATA;
    logic        SEQ_BUSY, DONE, ERR, TMO;
    logic [15:0] RDATA;
    logic [7:0]  STATUS;
    logic [22:0] ADDR;
    logic [15:0] CMD_DATA_OUT;
    logic [1:0]  OP;
    logic        EXECUTE;
    logic        BUSY = 1'b0;
    logic        LOAD_DATA = 1'b0;
    logic [15:0] DATA_IN = 16'h0;

    int assert_count = 0;
    int fail_count   = 0;

    int          busy_len = 3;
    int          busy_left = 0;
    int          rd_left = 0;
    int          ncyc = 0;
    int          done_count = 0;
    logic [15:0] resp_default = 16'h0000;
    logic [15:0] resp_q[$];
    logic [1:0]  log_op[$];
    logic [22:0] log_addr[$];
    logic [15:0] log_data[$];
    int          log_cyc[$];

    always #5 CLK = ~CLK;

    bpi_cmd_sequencer #(.POLL_MAX(8), .GUARD(2)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .CMD_REQ      (CMD_REQ),
        .CMD_CODE     (CMD_CODE),
        .USR_ADDR     (USR_ADDR),
        .USR_WDATA    (USR_WDATA),
        .SEQ_BUSY     (SEQ_BUSY),
        .DONE         (DONE),
        .ERR          (ERR),
        .TMO          (TMO),
        .RDATA        (RDATA),
        .STATUS       (STATUS),
        .ADDR         (ADDR),
        .CMD_DATA_OUT (CMD_DATA_OUT),
        .OP           (OP),
        .EXECUTE      (EXECUTE),
        .BUSY         (BUSY),
        .LOAD_DATA    (LOAD_DATA),
        .DATA_IN      (DATA_IN)
    );

    // Flash interface model: writes hold BUSY for busy_len cycles, reads return
    // the next queued word two cycles after EXECUTE.
    always @(negedge CLK) begin
        ncyc++;
        if (DONE === 1'b1) done_count++;
        if (RST) begin
            BUSY = 1'b0; LOAD_DATA = 1'b0; DATA_IN = 16'h0;
            busy_left = 0; rd_left = 0;
        end else begin
            LOAD_DATA = 1'b0;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) BUSY = 1'b0;
            end
            if (rd_left > 0) begin
                rd_left--;
                if (rd_left == 0) begin
                    LOAD_DATA = 1'b1;
                    DATA_IN = (resp_q.size() > 0) ? resp_q.pop_front() : resp_default;
                end
            end
            if (EXECUTE === 1'b1) begin
                log_op.push_back(OP);
                log_addr.push_back(ADDR);
                log_data.push_back(CMD_DATA_OUT);
                log_cyc.push_back(ncyc);
                if (OP == 2'd1 && busy_len > 0) begin
                    BUSY = 1'b1;
                    busy_left = busy_len;
                end else if (OP == 2'd2) begin
                    rd_left = 2;
                end
            end
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] code, input logic [22:0] a, input logic [15:0] d);
        @(negedge CLK);
        CMD_REQ = 1'b1; CMD_CODE = code; USR_ADDR = a; USR_WDATA = d;
        @(negedge CLK);
        CMD_REQ = 1'b0; CMD_CODE = ~code; USR_ADDR = ~a; USR_WDATA = ~d;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (DONE !== 1'b1 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check_output({tag, "_done_seen"}, 64'(DONE), 64'd1);
    endtask

    task automatic clear_log();
        log_op.delete(); log_addr.delete(); log_data.delete(); log_cyc.delete();
        resp_q.delete();
        done_count = 0;
    endtask

    function automatic int count_reads();
        int n = 0;
        foreach (log_op[i]) if (log_op[i] == 2'd2) n++;
        return n;
    endfunction

    function automatic logic addrs_all(input logic [22:0] a);
        foreach (log_addr[i]) if (log_addr[i] !== a) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        RST = 1'b1; CMD_REQ = 1'b0; CMD_CODE = 3'd0; USR_ADDR = '0; USR_WDATA = '0;
        repeat (3) @(negedge CLK);
        check_output("reset_ctrl", 64'({SEQ_BUSY, DONE, ERR, TMO, EXECUTE, OP}), 64'd0);
        check_output("reset_data", 64'({RDATA, STATUS, ADDR, CMD_DATA_OUT}), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        check_output("idle_busy", 64'(SEQ_BUSY), 64'd0);

        // Read word, BUSY never raised so completion rests on the guard alone
        clear_log(); busy_len = 0; resp_q.push_back(16'h55A4);
        apply_stimulus(3'd0, 23'h143216, 16'hBEEF);
        wait_done("rd");
        check_output("rd_rdata", 64'(RDATA), 64'h55A4);
        check_output("rd_err", 64'(ERR), 64'd0);
        @(negedge CLK);
        check_output("rd_busy_drop", 64'({SEQ_BUSY, DONE}), 64'd0);
        repeat (5) @(negedge CLK);
        check_output("rd_nsteps", 64'(log_op.size()), 64'd2);
        check_output("rd_step0", 64'({log_op[0], log_data[0]}), 64'({2'd1, 16'h00FF}));
        check_output("rd_step1", 64'({log_op[1], log_addr[1]}), 64'({2'd2, 23'h143216}));
        check_output("rd_guard_gap", 64'((log_cyc[1] - log_cyc[0]) >= 3), 64'd1);
        check_output("rd_done_once", 64'(done_count), 64'd1);

        // Program, with a stray request while busy and scrambled inputs after accept
        clear_log(); busy_len = 3;
        resp_q.push_back(16'h0000); resp_q.push_back(16'h0000); resp_q.push_back(16'h0080);
        apply_stimulus(3'd1, 23'h000245, 16'h3333);
        repeat (4) @(negedge CLK);
        CMD_REQ = 1'b1; CMD_CODE = 3'd2; USR_ADDR = 23'h7FFFFF;
        @(negedge CLK);
        CMD_REQ = 1'b0;
        wait_done("prog");
        check_output("prog_status", 64'(STATUS), 64'h80);
        check_output("prog_err_tmo", 64'({ERR, TMO}), 64'd0);
        repeat (6) @(negedge CLK);
        check_output("prog_nsteps", 64'(log_op.size()), 64'd7);
        check_output("prog_wr0", 64'(log_data[0]), 64'h0040);
        check_output("prog_wr1", 64'(log_data[1]), 64'h3333);
        check_output("prog_wr2", 64'({log_op[2], log_data[2]}), 64'({2'd1, 16'h0070}));
        check_output("prog_reads", 64'(count_reads()), 64'd3);
        check_output("prog_fin", 64'({log_op[6], log_data[6]}), 64'({2'd1, 16'h00FF}));
        check_output("prog_addr", 64'(addrs_all(23'h000245)), 64'd1);
        check_output("prog_done_once", 64'(done_count), 64'd1);

        // Erase with error status 0xA0: clear-status then read-array
        clear_log(); resp_q.push_back(16'h00A0);
        apply_stimulus(3'd2, 23'h010000, 16'h0000);
        wait_done("erase");
        check_output("erase_err_tmo", 64'({ERR, TMO}), 64'({1'b1, 1'b0}));
        check_output("erase_status", 64'(STATUS), 64'hA0);
        repeat (5) @(negedge CLK);
        check_output("erase_nsteps", 64'(log_op.size()), 64'd6);
        check_output("erase_clr", 64'({log_op[4], log_data[4]}), 64'({2'd1, 16'h0050}));
        check_output("erase_fin", 64'({log_op[5], log_data[5]}), 64'({2'd1, 16'h00FF}));

        // Poll timeout: status stuck at 0, POLL_MAX=8
        clear_log(); resp_default = 16'h0000;
        apply_stimulus(3'd2, 23'h00ABCD, 16'h0000);
        wait_done("tmo");
        check_output("tmo_flags", 64'({ERR, TMO}), 64'({1'b1, 1'b1}));
        repeat (5) @(negedge CLK);
        check_output("tmo_reads", 64'(count_reads()), 64'd8);
        check_output("tmo_nsteps", 64'(log_op.size()), 64'd12);
        check_output("tmo_fin", 64'({log_op[11], log_data[11]}), 64'({2'd1, 16'h00FF}));

        // Illegal code, plus a request coincident with DONE
        clear_log();
        apply_stimulus(3'd7, 23'h000001, 16'h0000);
        check_output("ill_cycle1", 64'({SEQ_BUSY, DONE}), 64'({1'b1, 1'b0}));
        @(negedge CLK);
        check_output("ill_done", 64'({DONE, ERR, TMO}), 64'({1'b1, 1'b1, 1'b0}));
        CMD_REQ = 1'b1; CMD_CODE = 3'd0;
        @(negedge CLK);
        CMD_REQ = 1'b0;
        check_output("ill_after", 64'({SEQ_BUSY, DONE, ERR}), 64'({1'b0, 1'b0, 1'b1}));
        repeat (4) @(negedge CLK);
        check_output("ill_no_exec", 64'(log_op.size()), 64'd0);

        // Read status
        clear_log(); resp_q.push_back(16'h0091);
        apply_stimulus(3'd5, 23'h000010, 16'h0000);
        wait_done("rds");
        check_output("rds_result", 64'({RDATA, STATUS, ERR}), 64'({16'h0091, 8'h91, 1'b0}));
        repeat (4) @(negedge CLK);
        check_output("rds_step0", 64'({log_op.size() == 2, log_data[0]}), 64'({1'b1, 16'h0070}));

        // Reset in the middle of an erase poll, then a clean read
        clear_log(); resp_default = 16'h0000;
        apply_stimulus(3'd2, 23'h020000, 16'h0000);
        for (int n = 0; n < 3000 && log_op.size() < 5; n++) @(negedge CLK);
        check_output("rst_reached_poll", 64'(log_op.size() >= 5), 64'd1);
        RST = 1'b1;
        @(negedge CLK);
        check_output("rst_ctrl", 64'({SEQ_BUSY, DONE, ERR, TMO, EXECUTE, OP}), 64'd0);
        check_output("rst_data", 64'({RDATA, STATUS, ADDR, CMD_DATA_OUT}), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        clear_log(); resp_q.push_back(16'h1234);
        apply_stimulus(3'd0, 23'h000007, 16'h0000);
        wait_done("rst_rd");
        check_output("rst_rd_result", 64'({RDATA, ERR}), 64'({16'h1234, 1'b0}));
        repeat (4) @(negedge CLK);
        check_output("rst_rd_steps", 64'({log_op.size() == 2, log_addr[1]}), 64'({1'b1, 23'h000007}));

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
